// File: rtl/oldland_bus_pkg.sv
// Shared definitions for oldland data-bus slaves: FSM states and byte-lane legality.
package oldland_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } bus_state_e;

  localparam logic [3:0] BSEL_B0 = 4'b0001;
  localparam logic [3:0] BSEL_B1 = 4'b0010;
  localparam logic [3:0] BSEL_B2 = 4'b0100;
  localparam logic [3:0] BSEL_B3 = 4'b1000;
  localparam logic [3:0] BSEL_H0 = 4'b0011;
  localparam logic [3:0] BSEL_H1 = 4'b1100;
  localparam logic [3:0] BSEL_W  = 4'b1111;

  // Only naturally aligned bytes, halfwords and full words are accepted.
  function automatic logic bytesel_legal(input logic [3:0] bsel);
    logic ok;
    case (bsel)
      BSEL_B0, BSEL_B1, BSEL_B2, BSEL_B3, BSEL_H0, BSEL_H1, BSEL_W: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/oldland_ram_1rw.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables and a registered read port.
module oldland_ram_1rw #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Contents are deliberately left unreset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/oldland_data_ram.sv
// Oldland CPU data-bus RAM slave: one request at a time, programmable wait states, ack/error response.
module oldland_data_ram
  import oldland_bus_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned SIZE_WORDS  = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_access,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_bytesel,
  input  logic        d_wr_en,
  input  logic [31:0] d_wr_val,
  output logic [31:0] d_data,
  output logic        d_ack,
  output logic        d_error
);

  localparam int unsigned AW        = $clog2(SIZE_WORDS);
  localparam logic [32:0] ADDR_LO   = {1'b0, ADDR_BASE};
  localparam logic [32:0] ADDR_HI   = ADDR_LO + 33'(4 * SIZE_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  bus_state_e    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [3:0]    bsel_q, bsel_d;
  logic          wr_q, wr_d;
  logic [31:0]   wval_q, wval_d;
  logic          legal_q, legal_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          load_q, load_d;

  logic          live_legal;
  logic [AW-1:0] live_idx;
  logic [AW-1:0] cur_idx;
  logic [3:0]    cur_bsel;
  logic          cur_wr;
  logic [31:0]   cur_wval;
  logic          cur_legal;
  logic          fire;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [31:0]   ram_rdata;

  // The 33-bit compare keeps a window ending at 2^32 from wrapping to zero.
  assign live_legal = ({1'b0, d_addr} >= ADDR_LO) && ({1'b0, d_addr} < ADDR_HI)
                      && bytesel_legal(d_bytesel);
  assign live_idx   = AW'((d_addr - ADDR_BASE) >> 2);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    bsel_d    = bsel_q;
    wr_d      = wr_q;
    wval_d    = wval_q;
    legal_d   = legal_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    load_d    = 1'b0;
    fire      = 1'b0;
    cur_idx   = idx_q;
    cur_bsel  = bsel_q;
    cur_wr    = wr_q;
    cur_wval  = wval_q;
    cur_legal = legal_q;
    case (state_q)
      ST_IDLE: begin
        // With zero wait states the RAM is accessed straight from the bus inputs.
        cur_idx   = live_idx;
        cur_bsel  = d_bytesel;
        cur_wr    = d_wr_en;
        cur_wval  = d_wr_val;
        cur_legal = live_legal;
        if (d_access) begin
          idx_d   = live_idx;
          bsel_d  = d_bytesel;
          wr_d    = d_wr_en;
          wval_d  = d_wr_val;
          legal_d = live_legal;
          if (WAIT_INIT == 4'd0) begin
            fire    = 1'b1;
            state_d = ST_RESP;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) begin
          fire    = 1'b1;
          cnt_d   = 4'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (fire) begin
      ack_d  = cur_legal;
      err_d  = !cur_legal;
      load_d = cur_legal && !cur_wr;
    end
  end

  assign ram_en = fire && cur_legal;
  assign ram_we = cur_wr ? cur_bsel : 4'b0000;

  oldland_ram_1rw #(
    .DEPTH (SIZE_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (cur_idx),
    .wdata_i (cur_wval),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      bsel_q  <= 4'd0;
      wr_q    <= 1'b0;
      wval_q  <= 32'd0;
      legal_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bsel_q  <= bsel_d;
      wr_q    <= wr_d;
      wval_q  <= wval_d;
      legal_q <= legal_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      load_q  <= load_d;
    end
  end

  // Read data is only exposed in the ack cycle of a load; stores and errors return zero.
  assign d_data  = load_q ? ram_rdata : 32'd0;
  assign d_ack   = ack_q;
  assign d_error = err_q;

endmodule
